// File: rtl/issue_ctrl.sv
// issue_ctrl: single-slot decode-to-execute issue stage with register scoreboard, illegal trap and flush.
// Ports: clk, rst_n (async, active-low); i_ifu_valid/o_ifu_ready decoder handshake; i_dec_* decoded
//   instruction; o_{alu,bju,agu}_valid / i_{alu,bju,agu}_ready per-unit issue handshake; o_opb, o_rs*_idx,
//   o_rd_idx, o_rd_wen, o_im, o_pc shared registered payload; i_wb_en/i_wb_idx write-back retire;
//   i_flush redirect; o_ilgl_exc/o_trap_pc illegal trap; o_hazard slot blocked by scoreboard.
// Optional: define CIRNO_ISSUE_WB_BYPASS_EN to let a same-cycle write-back clear a hazard.
`ifndef CIRNO_DEC_USELE
`define CIRNO_DEC_USELE 3
`endif
`ifndef CIRNO_DEC_OPB_SIZE
`define CIRNO_DEC_OPB_SIZE 8
`endif
module issue_ctrl #(
  parameter int SB_CNT_W = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_ifu_valid,
  output logic                           o_ifu_ready,
  input  logic                           i_dec_val,
  input  logic                           i_dec_ilgl,
  input  logic [`CIRNO_DEC_USELE-1:0]    i_dec_usele,
  input  logic [`CIRNO_DEC_OPB_SIZE-1:0] i_dec_opb,
  input  logic                           i_dec_rs1_ren,
  input  logic                           i_dec_rs2_ren,
  input  logic                           i_dec_rd_wen,
  input  logic [4:0]                     i_dec_rs1_idx,
  input  logic [4:0]                     i_dec_rs2_idx,
  input  logic [4:0]                     i_dec_rd_idx,
  input  logic [31:0]                    i_dec_im,
  input  logic [31:0]                    i_dec_pc,
  output logic                           o_alu_valid,
  input  logic                           i_alu_ready,
  output logic                           o_bju_valid,
  input  logic                           i_bju_ready,
  output logic                           o_agu_valid,
  input  logic                           i_agu_ready,
  output logic [`CIRNO_DEC_OPB_SIZE-1:0] o_opb,
  output logic [4:0]                     o_rs1_idx,
  output logic [4:0]                     o_rs2_idx,
  output logic [4:0]                     o_rd_idx,
  output logic                           o_rd_wen,
  output logic [31:0]                    o_im,
  output logic [31:0]                    o_pc,
  input  logic                           i_wb_en,
  input  logic [4:0]                     i_wb_idx,
  input  logic                           i_flush,
  output logic                           o_ilgl_exc,
  output logic [31:0]                    o_trap_pc,
  output logic                           o_hazard
);
  typedef enum logic [1:0] {EMPTY, HOLD, TRAP} state_t;
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic [`CIRNO_DEC_USELE-1:0] usele;
  logic rs1_ren, rs2_ren;
  logic [SB_CNT_W-1:0] cnt [32];
  logic [SB_CNT_W-1:0] cnt_n [32];
  logic [SB_CNT_W-1:0] hcnt [32];
  logic [31:0] inc, dec;
  logic hold, haz, iss, fire, acc;
  assign hold = state == HOLD;
  // Hazard view of the scoreboard; with bypass a same-cycle write-back is already subtracted.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      dec[i] = i_wb_en & (i_wb_idx == 5'(i)) & (i != 0);
`ifdef CIRNO_ISSUE_WB_BYPASS_EN
      hcnt[i] = (dec[i] & |cnt[i]) ? cnt[i] - 1'b1 : cnt[i];
`else
      hcnt[i] = cnt[i];
`endif
    end
  end
  assign haz = (rs1_ren & |o_rs1_idx & |hcnt[o_rs1_idx]) |
               (rs2_ren & |o_rs2_idx & |hcnt[o_rs2_idx]) |
               (o_rd_wen & |o_rd_idx & (hcnt[o_rd_idx] == CNT_MAX));
  assign iss = hold & ~haz & ~i_flush;
  assign o_alu_valid = iss & usele[0];
  assign o_bju_valid = iss & usele[1];
  assign o_agu_valid = iss & usele[2];
  assign fire = (o_alu_valid & i_alu_ready) | (o_bju_valid & i_bju_ready) | (o_agu_valid & i_agu_ready);
  assign o_ifu_ready = ~i_flush & ((state == EMPTY) | (hold & fire));
  assign acc = i_ifu_valid & o_ifu_ready;
  assign o_hazard = hold & haz;
  assign o_ilgl_exc = state == TRAP;
  // x0 never counts: inc[0] and dec[0] are always 0, so cnt[0] stays at reset value.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      inc[i] = fire & o_rd_wen & (o_rd_idx == 5'(i)) & (i != 0);
      cnt_n[i] = (inc[i] & ~dec[i]) ? cnt[i] + 1'b1 :
                 (dec[i] & ~inc[i] & |cnt[i]) ? cnt[i] - 1'b1 : cnt[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt <= '{default: '0};
      usele <= '0;
      rs1_ren <= 1'b0;
      rs2_ren <= 1'b0;
      o_opb <= '0;
      o_rs1_idx <= '0;
      o_rs2_idx <= '0;
      o_rd_idx <= '0;
      o_rd_wen <= 1'b0;
      o_im <= '0;
      o_pc <= '0;
      o_trap_pc <= '0;
    end else begin
      cnt <= cnt_n;
      state <= i_flush ? EMPTY :
               acc ? (i_dec_ilgl ? TRAP : i_dec_val ? HOLD : EMPTY) :
               fire ? EMPTY : state;
      if (acc & i_dec_ilgl) o_trap_pc <= i_dec_pc;
      if (acc & ~i_dec_ilgl & i_dec_val) begin
        usele <= i_dec_usele;
        rs1_ren <= i_dec_rs1_ren;
        rs2_ren <= i_dec_rs2_ren;
        o_opb <= i_dec_opb;
        o_rs1_idx <= i_dec_rs1_idx;
        o_rs2_idx <= i_dec_rs2_idx;
        o_rd_idx <= i_dec_rd_idx;
        o_rd_wen <= i_dec_rd_wen;
        o_im <= i_dec_im;
        o_pc <= i_dec_pc;
      end
    end
  end
endmodule
